// File: rtl/paint_pkg.sv
// Shared colour codes, canvas default and FSM state encoding for the brush stamper.
// The CLEAR state is only part of the encoding when BRUSH_CLEAR_EN is defined.
package paint_pkg;

    localparam int DEF_CANVAS_DIM = 128;

    typedef logic [2:0] color_t;

    localparam color_t ERASE  = 3'd0;
    localparam color_t RED    = 3'd1;
    localparam color_t GREEN  = 3'd2;
    localparam color_t BLUE   = 3'd3;
    localparam color_t YELLOW = 3'd4;
    localparam color_t PURPLE = 3'd5;
    localparam color_t WHITE  = 3'd6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STAMP = 2'd1,
        DONE  = 2'd2
`ifdef BRUSH_CLEAR_EN
        , CLEAR = 2'd3
`endif
    } state_t;

endpackage

// File: rtl/stamp_clip.sv
// Clips one axis of a brush square [c-r, c+r] to the canvas [0, CANVAS_DIM-1].
// Uses 9-bit signed arithmetic; an overflowing c+r only occurs when the low bound is already off-canvas.
module stamp_clip #(
    parameter int CANVAS_DIM = 128,
    parameter int CW         = 7
) (
    input  logic [7:0]    i_c,
    input  logic [1:0]    i_r,
    output logic [CW-1:0] o_lo,
    output logic [CW-1:0] o_hi,
    output logic          o_empty
);

    localparam logic signed [8:0] MAX_C = 9'(CANVAS_DIM - 1);

    logic signed [8:0] w_c;
    logic signed [8:0] w_r;
    logic signed [8:0] w_lo_raw;
    logic signed [8:0] w_hi_raw;
    logic signed [8:0] w_lo;
    logic signed [8:0] w_hi;
    logic              w_unused_bits;

    assign w_c      = $signed({1'b0, i_c});
    assign w_r      = $signed({7'd0, i_r});
    assign w_lo_raw = w_c - w_r;
    assign w_hi_raw = w_c + w_r;

    // Saturate both bounds onto the canvas and flag an empty span.
    always_comb begin
        w_lo    = (w_lo_raw < 9'sd0) ? 9'sd0 : w_lo_raw;
        w_hi    = (w_hi_raw > MAX_C) ? MAX_C : w_hi_raw;
        o_empty = (w_lo > w_hi);
        o_lo    = w_lo[CW-1:0];
        o_hi    = w_hi[CW-1:0];
    end

    assign w_unused_bits = ^{w_lo[8:CW], w_hi[8:CW]};

endmodule

// File: rtl/brush_stamper.sv
// Paints a clipped (2r+1)^2 square of one colour, emitting one pixel write per cycle row-major.
// Define BRUSH_CLEAR_EN to add a full-canvas ERASE pass triggered by the clear input.
module brush_stamper
    import paint_pkg::*;
#(
    parameter int CANVAS_DIM = DEF_CANVAS_DIM,
    parameter int MAX_RADIUS = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req,
    input  logic [7:0]                    cx,
    input  logic [7:0]                    cy,
    input  logic [1:0]                    radius,
    input  logic [2:0]                    color,
    input  logic                          clear,
    output logic                          busy,
    output logic                          done,
    output logic                          we,
    output logic [$clog2(CANVAS_DIM)-1:0] wx,
    output logic [$clog2(CANVAS_DIM)-1:0] wy,
    output logic [2:0]                    wColor
);

    localparam int            CW        = $clog2(CANVAS_DIM);
    localparam logic [1:0]    RAD_MAX   = 2'(MAX_RADIUS);
    localparam logic [CW-1:0] ZERO      = {CW{1'b0}};
    localparam logic [CW-1:0] ONE       = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] MAX_COORD = CW'(CANVAS_DIM - 1);

    state_t        r_state, w_state_nx;
    logic [CW-1:0] r_lo_x, r_hi_x, r_hi_y;
    logic [CW-1:0] w_lo_x_nx, w_hi_x_nx, w_hi_y_nx;
    logic          r_busy, r_done, r_we;
    logic          w_busy_nx, w_done_nx, w_we_nx;
    logic [CW-1:0] r_wx, r_wy, w_wx_nx, w_wy_nx;
    color_t        r_wcolor, w_wcolor_nx;

    logic [1:0]    w_rad;
    logic [CW-1:0] w_clip_lo_x, w_clip_hi_x, w_clip_lo_y, w_clip_hi_y;
    logic          w_empty_x, w_empty_y;
    logic          w_row_end, w_last;
    logic [CW-1:0] w_adv_wx, w_adv_wy;

    assign w_rad = (radius > RAD_MAX) ? RAD_MAX : radius;

    stamp_clip #(.CANVAS_DIM(CANVAS_DIM), .CW(CW)) u_clip_x (
        .i_c(cx), .i_r(w_rad), .o_lo(w_clip_lo_x), .o_hi(w_clip_hi_x), .o_empty(w_empty_x)
    );

    stamp_clip #(.CANVAS_DIM(CANVAS_DIM), .CW(CW)) u_clip_y (
        .i_c(cy), .i_r(w_rad), .o_lo(w_clip_lo_y), .o_hi(w_clip_hi_y), .o_empty(w_empty_y)
    );

    // Scan position of the pixel following the one currently on the write port.
    assign w_row_end = (r_wx == r_hi_x);
    assign w_last    = w_row_end && (r_wy == r_hi_y);
    assign w_adv_wx  = w_row_end ? r_lo_x : (r_wx + ONE);
    assign w_adv_wy  = w_row_end ? (r_wy + ONE) : r_wy;

`ifndef BRUSH_CLEAR_EN
    logic w_unused_clear;
    assign w_unused_clear = clear;
`endif

    // Next-state and next-output logic; outputs are computed one cycle ahead and registered.
    always_comb begin
        w_state_nx  = r_state;
        w_lo_x_nx   = r_lo_x;
        w_hi_x_nx   = r_hi_x;
        w_hi_y_nx   = r_hi_y;
        w_we_nx     = 1'b0;
        w_done_nx   = 1'b0;
        w_wx_nx     = r_wx;
        w_wy_nx     = r_wy;
        w_wcolor_nx = r_wcolor;
        case (r_state)
            IDLE: begin
`ifdef BRUSH_CLEAR_EN
                if (clear) begin
                    w_state_nx  = CLEAR;
                    w_lo_x_nx   = ZERO;
                    w_hi_x_nx   = MAX_COORD;
                    w_hi_y_nx   = MAX_COORD;
                    w_we_nx     = 1'b1;
                    w_wx_nx     = ZERO;
                    w_wy_nx     = ZERO;
                    w_wcolor_nx = ERASE;
                end else
`endif
                if (req) begin
                    w_lo_x_nx   = w_clip_lo_x;
                    w_hi_x_nx   = w_clip_hi_x;
                    w_hi_y_nx   = w_clip_hi_y;
                    w_wcolor_nx = color;
                    if (w_empty_x || w_empty_y) begin
                        w_state_nx = DONE;
                        w_done_nx  = 1'b1;
                    end else begin
                        w_state_nx = STAMP;
                        w_we_nx    = 1'b1;
                        w_wx_nx    = w_clip_lo_x;
                        w_wy_nx    = w_clip_lo_y;
                    end
                end else begin
                    w_state_nx = IDLE;
                end
            end
            STAMP: begin
                if (w_last) begin
                    w_state_nx = DONE;
                    w_done_nx  = 1'b1;
                end else begin
                    w_we_nx = 1'b1;
                    w_wx_nx = w_adv_wx;
                    w_wy_nx = w_adv_wy;
                end
            end
`ifdef BRUSH_CLEAR_EN
            CLEAR: begin
                if (w_last) begin
                    w_state_nx = DONE;
                    w_done_nx  = 1'b1;
                end else begin
                    w_we_nx = 1'b1;
                    w_wx_nx = w_adv_wx;
                    w_wy_nx = w_adv_wy;
                end
            end
`endif
            DONE: begin
                w_state_nx = IDLE;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
        w_busy_nx = (w_state_nx != IDLE);
    end

    // State, scan bounds and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_lo_x   <= ZERO;
            r_hi_x   <= ZERO;
            r_hi_y   <= ZERO;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_we     <= 1'b0;
            r_wx     <= ZERO;
            r_wy     <= ZERO;
            r_wcolor <= ERASE;
        end else begin
            r_state  <= w_state_nx;
            r_lo_x   <= w_lo_x_nx;
            r_hi_x   <= w_hi_x_nx;
            r_hi_y   <= w_hi_y_nx;
            r_busy   <= w_busy_nx;
            r_done   <= w_done_nx;
            r_we     <= w_we_nx;
            r_wx     <= w_wx_nx;
            r_wy     <= w_wy_nx;
            r_wcolor <= w_wcolor_nx;
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign we     = r_we;
    assign wx     = r_wx;
    assign wy     = r_wy;
    assign wColor = r_wcolor;

endmodule

// File: tb/tb_brush_stamper.sv
// Randomized self-checking bench for brush_stamper against a pixel-list reference model.
// Honours BRUSH_CLEAR_EN so the same bench covers both builds.
module tb_brush_stamper;
    import paint_pkg::*;

    localparam int DIM = 128;

    logic       clk = 1'b0;
    logic       reset, req, clear;
    logic [7:0] cx, cy;
    logic [1:0] radius;
    logic [2:0] color;
    logic       busy, done, we;
    logic [6:0] wx, wy;
    logic [2:0] wColor;

    int n_checks = 0;
    int n_fail   = 0;

    brush_stamper #(.CANVAS_DIM(DIM), .MAX_RADIUS(3)) dut (
        .clk(clk), .reset(reset), .req(req), .cx(cx), .cy(cy), .radius(radius),
        .color(color), .clear(clear), .busy(busy), .done(done), .we(we),
        .wx(wx), .wy(wy), .wColor(wColor)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Issues one operation and checks every cycle until the return to IDLE.
    task automatic run_op(input int c_x, input int c_y, input int r, input int col,
                          input bit do_clear, input bit noisy);
        int  exp_x[$];
        int  exp_y[$];
        int  exp_col;
        bit  clr_mode;
        int  xl, xh, yl, yh;
        clr_mode = 1'b0;
`ifdef BRUSH_CLEAR_EN
        clr_mode = do_clear;
`endif
        if (clr_mode) begin
            for (int y = 0; y < DIM; y++)
                for (int x = 0; x < DIM; x++) begin
                    exp_x.push_back(x);
                    exp_y.push_back(y);
                end
            exp_col = int'(ERASE);
        end else begin
            xl = (c_x - r < 0) ? 0 : c_x - r;
            xh = (c_x + r > DIM - 1) ? DIM - 1 : c_x + r;
            yl = (c_y - r < 0) ? 0 : c_y - r;
            yh = (c_y + r > DIM - 1) ? DIM - 1 : c_y + r;
            for (int y = yl; y <= yh; y++)
                for (int x = xl; x <= xh; x++) begin
                    exp_x.push_back(x);
                    exp_y.push_back(y);
                end
            exp_col = col;
        end

        @(posedge clk); #1;
        check_eq("idle_before", 32'({busy, done, we}), 32'd0);
        req    = 1'b1;
        clear  = do_clear;
        cx     = 8'(c_x);
        cy     = 8'(c_y);
        radius = 2'(r);
        color  = 3'(col);
        @(posedge clk); #1;
        req   = 1'b0;
        clear = 1'b0;
        for (int i = 0; i < exp_x.size(); i++) begin
            check_eq("write", 32'({we, wx, wy, wColor}),
                     32'({1'b1, 7'(exp_x[i]), 7'(exp_y[i]), 3'(exp_col)}));
            check_eq("busy", 32'(busy), 32'd1);
            if (noisy) begin
                req    = 1'($urandom_range(0, 1));
                clear  = 1'($urandom_range(0, 1));
                cx     = 8'($urandom);
                cy     = 8'($urandom);
                radius = 2'($urandom);
                color  = 3'($urandom);
            end
            @(posedge clk); #1;
        end
        req   = 1'b0;
        clear = 1'b0;
        check_eq("done", 32'({busy, done, we}), 32'b110);
        @(posedge clk); #1;
        check_eq("idle_after", 32'({busy, done, we}), 32'd0);
    endtask

    // Radius-3 stamp aborted by reset during its 4th write.
    task automatic run_reset_abort();
        @(posedge clk); #1;
        req = 1'b1; cx = 8'd50; cy = 8'd50; radius = 2'd3; color = 3'(GREEN);
        @(posedge clk); #1;
        req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("abort_write", 32'({we, wx, wy, wColor}),
                     32'({1'b1, 7'(47 + i), 7'd47, 3'(GREEN)}));
            if (i < 3) begin
                @(posedge clk); #1;
            end
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_eq("abort_outputs", 32'({busy, done, we, wx, wy, wColor}), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check_eq("abort_quiet", 32'({busy, done, we}), 32'd0);
        end
    endtask

    initial begin
        int c_x, c_y;
        reset = 1'b1; req = 1'b0; clear = 1'b0;
        cx = 8'd0; cy = 8'd0; radius = 2'd0; color = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_state", 32'({busy, done, we, wx, wy, wColor}), 32'd0);
        reset = 1'b0;

        run_op(10, 20, 1, int'(RED), 1'b0, 1'b0);
        run_op(0, 0, 3, int'(BLUE), 1'b0, 1'b0);
        run_op(127, 127, 2, int'(YELLOW), 1'b0, 1'b0);
        run_op(200, 5, 3, int'(WHITE), 1'b0, 1'b0);
        run_op(64, 64, 0, int'(PURPLE), 1'b0, 1'b1);
        run_reset_abort();

        for (int k = 0; k < 30; k++) begin
            case ($urandom_range(0, 3))
                0:       begin c_x = $urandom_range(0, 255);   c_y = $urandom_range(0, 255);   end
                1:       begin c_x = $urandom_range(0, 4);     c_y = $urandom_range(0, 127);   end
                2:       begin c_x = $urandom_range(123, 131); c_y = $urandom_range(0, 4);     end
                default: begin c_x = $urandom_range(0, 127);   c_y = $urandom_range(124, 135); end
            endcase
            run_op(c_x, c_y, int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), 1'b0, 1'b1);
        end

        run_op(10, 20, 1, int'(RED), 1'b1, 1'b1);
        run_op(5, 6, 2, int'(GREEN), 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
